// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch stage: state encoding and the
// default address width, reset PC and halt encoding.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int          DEFAULT_AW        = 10;
    localparam int unsigned DEFAULT_RESET_PC  = 0;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/instruction_fetch_pc_register.sv
// Program counter flop: redirect load beats increment, increment wraps
// modulo 2^AW, otherwise hold.
module pc_register #(
    parameter int          AW       = 10,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] target,
    input  logic          inc,
    output logic [AW-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= AW'(RESET_PC);
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + AW'(1);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses the instruction memory and registers the
// returned word into the IF/ID register, with stall, redirect and halt control.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int          AW        = DEFAULT_AW,
    parameter int unsigned RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          START,
    input  logic          STALL,
    input  logic          REDIRECT,
    input  logic [AW-1:0] TARGET,
    output logic [AW-1:0] IM_ADDR,
    input  logic [31:0]   IM_Q,
    output logic [31:0]   IF_INSTR,
    output logic [AW-1:0] IF_PC,
    output logic          IF_VALID,
    output logic          HALTED,
    output logic [31:0]   FETCH_COUNT
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic         do_redirect;
    logic         do_issue;
    logic         do_halt;

    pc_register #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk    (CLK),
        .rst_n  (RESET),
        .load   (do_redirect),
        .target (TARGET),
        .inc    (do_issue),
        .pc     (IM_ADDR)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Redirect outranks stall because the word at the current PC is wrong-path;
    // halt detection only happens when the fetched word would actually issue.
    always_comb begin
        state_next  = state;
        do_redirect = 1'b0;
        do_issue    = 1'b0;
        do_halt     = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (REDIRECT) begin
                    do_redirect = 1'b1;
                end else if (!STALL) begin
                    if (IM_Q == HALT_WORD) begin
                        do_halt    = 1'b1;
                        state_next = HALT;
                    end else begin
                        do_issue = 1'b1;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            IF_INSTR    <= 32'd0;
            IF_PC       <= '0;
            IF_VALID    <= 1'b0;
            HALTED      <= 1'b0;
            FETCH_COUNT <= 32'd0;
        end else begin
            if (do_redirect || do_halt) begin
                IF_VALID <= 1'b0;
            end else if (do_issue) begin
                IF_INSTR    <= IM_Q;
                IF_PC       <= IM_ADDR;
                IF_VALID    <= 1'b1;
                FETCH_COUNT <= FETCH_COUNT + 32'd1;
            end
            if (do_halt) begin
                HALTED <= 1'b1;
            end
        end
    end

endmodule
